// File: rtl/ines_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ines_loader
//  Purpose  : Parses an iNES image from a byte stream, validates the header,
//             and writes PRG/CHR payload into cartridge memory with a
//             one-cycle write strobe. Publishes mapper and geometry fields.
//  Revision : 1.0  initial release
// ============================================================================
module ines_loader #(
  parameter logic [21:0] CHR_BASE      = 22'h200000,
  parameter int          MAX_PRG_BANKS = 32,
  parameter int          MAX_CHR_BANKS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reload,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_write,
  output logic [7:0]  mapper,
  output logic [7:0]  prg_banks,
  output logic [7:0]  chr_banks,
  output logic        mirror_v,
  output logic        four_screen,
  output logic        chr_ram,
  output logic        header_valid,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_HEADER  = 3'd0,
    S_TRAINER = 3'd1,
    S_PRG     = 3'd2,
    S_CHR     = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  localparam logic [7:0]  MAX_PRG      = MAX_PRG_BANKS[7:0];
  localparam logic [7:0]  MAX_CHR      = MAX_CHR_BANKS[7:0];
  localparam logic [21:0] TRAINER_LAST = 22'd511;

  state_t      state, state_next;
  logic [21:0] count, count_next;
  logic [21:0] mem_addr_next;
  logic [7:0]  mem_data_next;
  logic        mem_write_next;
  logic [7:0]  mapper_next, prg_banks_next, chr_banks_next;
  logic        mirror_v_next, four_screen_next, chr_ram_next;
  logic        header_valid_next;
  logic        trainer, trainer_next;

  logic [21:0] prg_last;
  logic [21:0] chr_last;
  logic [7:0]  magic_byte;
  logic        size_bad;

  // Last byte index of each payload section; the counter stops on equality so it never wraps.
  assign prg_last = {prg_banks, 14'b0} - 22'd1;
  assign chr_last = {1'b0, chr_banks, 13'b0} - 22'd1;

  assign size_bad = (prg_banks == 8'd0) || (prg_banks > MAX_PRG) || (chr_banks > MAX_CHR);

  assign done  = (state == S_DONE);
  assign error = (state == S_ERROR);

  // Expected "NES\x1A" signature byte for the current header position.
  always_comb begin
    magic_byte = 8'h4E;
    case (count[1:0])
      2'd0:    magic_byte = 8'h4E;
      2'd1:    magic_byte = 8'h45;
      2'd2:    magic_byte = 8'h53;
      default: magic_byte = 8'h1A;
    endcase
  end

  // Next-state and next-output logic: one accepted byte per in_valid cycle.
  always_comb begin
    state_next        = state;
    count_next        = count;
    mem_addr_next     = mem_addr;
    mem_data_next     = mem_data;
    mem_write_next    = 1'b0;
    mapper_next       = mapper;
    prg_banks_next    = prg_banks;
    chr_banks_next    = chr_banks;
    mirror_v_next     = mirror_v;
    four_screen_next  = four_screen;
    chr_ram_next      = chr_ram;
    header_valid_next = header_valid;
    trainer_next      = trainer;

    if (in_valid) begin
      case (state)
        S_HEADER: begin
          count_next = count + 22'd1;
          case (count[3:0])
            4'd0, 4'd1, 4'd2, 4'd3: begin
              if (in_data != magic_byte) state_next = S_ERROR;
            end
            4'd4: prg_banks_next = in_data;
            4'd5: begin
              chr_banks_next = in_data;
              chr_ram_next   = (in_data == 8'd0);
            end
            4'd6: begin
              mirror_v_next    = in_data[0];
              trainer_next     = in_data[2];
              four_screen_next = in_data[3];
              mapper_next      = {mapper[7:4], in_data[7:4]};
            end
            4'd7: mapper_next = {in_data[7:4], mapper[3:0]};
            4'd15: begin
              count_next = '0;
              if (size_bad) begin
                state_next = S_ERROR;
              end else begin
                header_valid_next = 1'b1;
                state_next        = trainer ? S_TRAINER : S_PRG;
              end
            end
            default: ;
          endcase
        end
        S_TRAINER: begin
          if (count == TRAINER_LAST) begin
            count_next = '0;
            state_next = S_PRG;
          end else begin
            count_next = count + 22'd1;
          end
        end
        S_PRG: begin
          mem_write_next = 1'b1;
          mem_addr_next  = count;
          mem_data_next  = in_data;
          if (count == prg_last) begin
            count_next = '0;
            state_next = (chr_banks != 8'd0) ? S_CHR : S_DONE;
          end else begin
            count_next = count + 22'd1;
          end
        end
        S_CHR: begin
          mem_write_next = 1'b1;
          mem_addr_next  = CHR_BASE + count;
          mem_data_next  = in_data;
          if (count == chr_last) begin
            count_next = '0;
            state_next = S_DONE;
          end else begin
            count_next = count + 22'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; reset or reload abort everything, dropping any same-cycle byte.
  always_ff @(posedge clock) begin
    if (reset || reload) begin
      state        <= S_HEADER;
      count        <= '0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_write    <= 1'b0;
      mapper       <= '0;
      prg_banks    <= '0;
      chr_banks    <= '0;
      mirror_v     <= 1'b0;
      four_screen  <= 1'b0;
      chr_ram      <= 1'b0;
      header_valid <= 1'b0;
      trainer      <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      mem_addr     <= mem_addr_next;
      mem_data     <= mem_data_next;
      mem_write    <= mem_write_next;
      mapper       <= mapper_next;
      prg_banks    <= prg_banks_next;
      chr_banks    <= chr_banks_next;
      mirror_v     <= mirror_v_next;
      four_screen  <= four_screen_next;
      chr_ram      <= chr_ram_next;
      header_valid <= header_valid_next;
      trainer      <= trainer_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ines_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ines_loader
//  Purpose  : Self-checking bench for ines_loader. Images are described as a
//             queue of byte records, each carrying the write it must cause.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ines_loader;

  localparam logic [21:0] CHR_BASE = 22'h200000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reload = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic [21:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_write;
  logic [7:0]  mapper, prg_banks, chr_banks;
  logic        mirror_v, four_screen, chr_ram, header_valid, done, error;

  ines_loader dut (
    .clock(clock), .reset(reset), .reload(reload), .in_data(in_data), .in_valid(in_valid),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .mapper(mapper), .prg_banks(prg_banks), .chr_banks(chr_banks),
    .mirror_v(mirror_v), .four_screen(four_screen), .chr_ram(chr_ram),
    .header_valid(header_valid), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // One stream byte and the write it must produce one edge later.
  typedef struct {
    logic [7:0]  data;
    bit          wr;
    logic [21:0] addr;
    bit          last;
  } rec_t;

  // Header table vector: header bytes 4..7 and the expected verdict.
  typedef struct {
    logic [7:0] h4, h5, h6, h7;
    bit         bad;
    logic [7:0] map;
    bit         cram;
  } hv_t;

  rec_t stream[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   exp_done = 1'b0;
  bit   exp_error = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Apply one cycle of inputs, then check the outputs that edge produced.
  task automatic tick(input bit v, input logic [7:0] d, input bit rl, input bit ewr, input logic [21:0] ea);
    in_valid = v;
    in_data  = d;
    reload   = rl;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    reload   = 1'b0;
    chk("mem_write", 32'(mem_write), 32'(ewr));
    if (ewr) begin
      chk("mem_addr", 32'(mem_addr), 32'(ea));
      chk("mem_data", 32'(mem_data), 32'(d));
    end
    chk("done", 32'(done), 32'(exp_done));
    chk("error", 32'(error), 32'(exp_error));
  endtask

  task automatic do_reload();
    exp_done  = 1'b0;
    exp_error = 1'b0;
    tick(1'b0, 8'h00, 1'b1, 1'b0, 22'd0);
  endtask

  task automatic push(input logic [7:0] d, input bit wr, input logic [21:0] a, input bit last);
    rec_t r;
    r.data = d; r.wr = wr; r.addr = a; r.last = last;
    stream.push_back(r);
  endtask

  task automatic build_header(input logic [7:0] h4, h5, h6, h7);
    push(8'h4E, 1'b0, 22'd0, 1'b0);
    push(8'h45, 1'b0, 22'd0, 1'b0);
    push(8'h53, 1'b0, 22'd0, 1'b0);
    push(8'h1A, 1'b0, 22'd0, 1'b0);
    push(h4, 1'b0, 22'd0, 1'b0);
    push(h5, 1'b0, 22'd0, 1'b0);
    push(h6, 1'b0, 22'd0, 1'b0);
    push(h7, 1'b0, 22'd0, 1'b0);
    for (int i = 0; i < 8; i++) push(8'($urandom), 1'b0, 22'd0, 1'b0);
  endtask

  // Payload layout: optional 512-byte trainer, PRG at 0, CHR at CHR_BASE.
  task automatic build_payload(input logic [7:0] h4, h5, h6, input bit rnd);
    int prg_n, chr_n;
    logic [21:0] a;
    prg_n = int'(h4) * 16384;
    chr_n = int'(h5) * 8192;
    if (h6[2]) for (int i = 0; i < 512; i++) push(8'($urandom), 1'b0, 22'd0, 1'b0);
    for (int i = 0; i < prg_n; i++) begin
      a = 22'(i);
      push(rnd ? 8'($urandom) : a[7:0], 1'b1, a, (chr_n == 0) && (i == prg_n - 1));
    end
    for (int i = 0; i < chr_n; i++) begin
      a = CHR_BASE + 22'(i);
      push(rnd ? 8'($urandom) : a[7:0], 1'b1, a, i == chr_n - 1);
    end
  endtask

  // Drive up to n queued records with random idle gaps, then discard the rest.
  task automatic run_stream(input int n, input int gap_pct);
    rec_t r;
    int k;
    k = 0;
    while (k < n && stream.size() > 0) begin
      while ($urandom_range(99) < gap_pct) tick(1'b0, 8'($urandom), 1'b0, 1'b0, 22'd0);
      r = stream.pop_front();
      if (r.last) exp_done = 1'b1;
      tick(1'b1, r.data, 1'b0, r.wr, r.addr);
      k++;
    end
    stream.delete();
  endtask

  task automatic check_fields(input logic [7:0] p, c, m, input bit mv, fs, cr, hv);
    chk("prg_banks", 32'(prg_banks), 32'(p));
    chk("chr_banks", 32'(chr_banks), 32'(c));
    chk("mapper", 32'(mapper), 32'(m));
    chk("mirror_v", 32'(mirror_v), 32'(mv));
    chk("four_screen", 32'(four_screen), 32'(fs));
    chk("chr_ram", 32'(chr_ram), 32'(cr));
    chk("header_valid", 32'(header_valid), 32'(hv));
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hv_t tbl[8];
    rec_t r;

    tbl[0] = '{8'h02, 8'h01, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{8'h01, 8'h00, 8'h10, 8'h40, 1'b0, 8'h41, 1'b1};
    tbl[2] = '{8'h21, 8'h01, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{8'h00, 8'h01, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[4] = '{8'h20, 8'h10, 8'h08, 8'hF0, 1'b0, 8'hF0, 1'b0};
    tbl[5] = '{8'h01, 8'h11, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[6] = '{8'hFF, 8'h00, 8'hF5, 8'hA0, 1'b1, 8'hAF, 1'b1};
    tbl[7] = '{8'h04, 8'h08, 8'h04, 8'h30, 1'b0, 8'h30, 1'b0};

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    check_fields(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Header validation table.
    for (int v = 0; v < 8; v++) begin
      do_reload();
      build_header(tbl[v].h4, tbl[v].h5, tbl[v].h6, tbl[v].h7);
      run_stream(15, 0);
      exp_error = tbl[v].bad;
      tick(1'b1, 8'($urandom), 1'b0, 1'b0, 22'd0);
      check_fields(tbl[v].h4, tbl[v].h5, tbl[v].map, tbl[v].h6[0], tbl[v].h6[3],
                   tbl[v].cram, !tbl[v].bad);
      if (tbl[v].bad) for (int i = 0; i < 3; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0, 22'd0);
    end

    // Full image: 2 PRG banks, 1 CHR bank, data equals address low byte.
    do_reload();
    build_header(8'h02, 8'h01, 8'h01, 8'h00);
    run_stream(16, 0);
    check_fields(8'h02, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    build_payload(8'h02, 8'h01, 8'h01, 1'b0);
    run_stream(40960, 0);
    chk("full_done", 32'(done), 32'd1);
    for (int i = 0; i < 20; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0, 22'd0);

    // Trainer: 512 discarded bytes, the next byte writes address 0.
    do_reload();
    build_header(8'h01, 8'h00, 8'h04, 8'h00);
    build_payload(8'h01, 8'h00, 8'h04, 1'b1);
    run_stream(16 + 512 + 5, 0);

    // Bad signature at byte 2, then over-read bytes with no writes.
    do_reload();
    tick(1'b1, 8'h4E, 1'b0, 1'b0, 22'd0);
    tick(1'b1, 8'h45, 1'b0, 1'b0, 22'd0);
    exp_error = 1'b1;
    tick(1'b1, 8'h54, 1'b0, 1'b0, 22'd0);
    chk("magic_header_valid", 32'(header_valid), 32'd0);
    for (int i = 0; i < 100; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0, 22'd0);

    // Good image with random gaps, aborted by reload at PRG byte 1000.
    do_reload();
    build_header(8'h01, 8'h02, 8'h01, 8'h00);
    build_payload(8'h01, 8'h02, 8'h01, 1'b1);
    run_stream(16 + 1000, 25);
    r.data = 8'($urandom);
    tick(1'b1, r.data, 1'b1, 1'b0, 22'd0);
    check_fields(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Next bytes are a fresh header: mapper 0x41 with CHR RAM, PRG only.
    build_header(8'h01, 8'h00, 8'h10, 8'h40);
    run_stream(16, 25);
    check_fields(8'h01, 8'h00, 8'h41, 1'b0, 1'b0, 1'b1, 1'b1);
    build_payload(8'h01, 8'h00, 8'h10, 1'b1);
    run_stream(16384, 12);
    chk("second_done", 32'(done), 32'd1);
    for (int i = 0; i < 10; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0, 22'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ines_loader.md
Name: ines_loader

Overview:
- Consumes the byte stream produced by the flash loader: one byte per data-valid pulse, starting at the image offset selected by the game index.
- Parses the 16-byte iNES header and validates it.
- Writes PRG-ROM and CHR-ROM payload bytes into the cartridge memory map with a one-cycle write strobe.
- Publishes the mapper and geometry fields that the cartridge/mapper logic and the memory arbiter need.

Parameters:
- CHR_BASE, 22'h200000, byte address where CHR data begins in cartridge memory. PRG data always starts at 0.
- MAX_PRG_BANKS, 32, maximum accepted PRG size in 16 KiB banks.
- MAX_CHR_BANKS, 16, maximum accepted CHR size in 8 KiB banks.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- reload  in  1  restart parsing from header byte 0. Driven together with the flash loader reload.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid this cycle. No back-pressure: every valid byte must be taken.
- mem_addr  out  22  write byte address.
- mem_data  out  8  write byte.
- mem_write  out  1  one-cycle write strobe.
- mapper  out  8  {hdr7[7:4], hdr6[7:4]}.
- prg_banks  out  8  hdr4.
- chr_banks  out  8  hdr5.
- mirror_v  out  1  hdr6[0].
- four_screen  out  1  hdr6[3].
- chr_ram  out  1  1 when hdr5==0.
- header_valid  out  1  header fields stable and checked.
- done  out  1  image fully written.
- error  out  1  bad magic or unsupported size.

Behaviour:
- Reset or reload: state=HEADER, byte counter=0, mem_write=0, mem_addr=0, mem_data=0, all flag and field outputs 0.
- Reload takes priority over in_valid in the same cycle; that byte is dropped.
- States: HEADER, TRAINER, PRG, CHR, DONE, ERROR.
- HEADER:
  - Counts accepted bytes 0..15 and latches bytes 4..7.
  - Bytes 0..3 are compared on acceptance against 4E 45 53 1A. Any mismatch goes to ERROR on that cycle.
  - Bytes 8..15 are ignored.
  - On byte 15, the size check runs: prg_banks==0, prg_banks>MAX_PRG_BANKS, or chr_banks>MAX_CHR_BANKS goes to ERROR.
  - If the size check passes: header_valid<=1, then next state is TRAINER if hdr6[2] is set, else PRG.
- TRAINER: discards exactly 512 bytes with no writes, then goes to PRG.
- PRG:
  - Byte n (n from 0) gives mem_addr<=n, mem_data<=in_data, mem_write<=1 on the next edge. Latency is 1 cycle.
  - Total bytes = prg_banks*16384. The counter is 22 bits and the byte count is computed as {prg_banks,14'b0} truncated to 22 bits.
  - After the last PRG byte: go to CHR if chr_banks!=0, else DONE.
- CHR:
  - Byte m gives mem_addr<=CHR_BASE+m, using the same strobe timing as PRG.
  - Total bytes = chr_banks*8192.
  - After the last CHR byte, go to DONE.
- done rises on the same edge as the final mem_write pulse.
- DONE / ERROR:
  - Further in_valid bytes are ignored, with no writes. The flash loader over-reads past the image end, so these bytes are expected.
  - The state holds until reload or reset.
  - error=1 is held in ERROR. header_valid stays 0 if the error came from the header.
- mem_write is 0 in every cycle not directly following an accepted payload byte. in_valid gaps of any length are tolerated.
- Reset or reload mid-payload aborts immediately. No further writes occur, and the next byte is treated as header byte 0.
- The counter never wraps: the last byte is detected by equality to total-1 before incrementing.

Test Plan:
- Header 4E 45 53 1A 02 01 01 00 + 8 zeros, then 32768 PRG bytes and 8192 CHR bytes (value = addr[7:0]):
  - expect 32768 writes at 0..0x7FFF, then 8192 writes at 0x200000..0x201FFF;
  - prg_banks=2, chr_banks=1, mirror_v=1, mapper=0;
  - done rises with the last write.
- Header with hdr5=0, hdr6=0x10, hdr7=0x40, hdr4=1:
  - mapper=0x41, chr_ram=1;
  - 16384 PRG writes, then done, with no CHR writes.
- Header with hdr6 bit2 set:
  - first 512 payload bytes produce no writes;
  - byte 513 writes addr 0.
- Byte 2 = 0x54:
  - error=1 on the next edge, header_valid=0;
  - 100 further valid bytes produce zero writes;
  - reload, then a good image loads correctly.
- hdr4=0x21 with default MAX_PRG_BANKS gives error after byte 15. hdr4=0 also gives error.
- Good image with random in_valid gaps; reload asserted at PRG byte 1000 simultaneously with in_valid:
  - that byte gets no write;
  - next bytes are re-parsed as a header;
  - second image writes start at addr 0.
